// File: rtl/mux3_rr_arbiter_pkg.sv
// mux3_rr_arbiter_pkg
//   Shared definitions for the 3-requester round-robin mux arbiter:
//   FSM state encoding, requester count, default hold limit and small
//   helpers used by both the arbiter and its winner-selection block.
package mux3_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_t;

   localparam int unsigned NUM_REQ          = 3;
   localparam int unsigned DEFAULT_MAX_HOLD = 15;

   // Smallest counter width able to hold max_hold, never narrower than 1 bit.
   function automatic int unsigned hold_width(input int unsigned max_hold);
      if (max_hold < 2) begin
         return 1;
      end
      return $clog2(max_hold + 1);
   endfunction

   // One-hot encoding of a requester index; index 3 is not a requester.
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] v;
      case (idx)
         2'd0:    v = 3'b001;
         2'd1:    v = 3'b010;
         2'd2:    v = 3'b100;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   // Requester examined at position 'step' of the round-robin order that
   // follows 'last': step 0 is (last+1) mod 3, step 2 is last itself.
   // An out-of-range last is treated as 2 so requester 0 leads.
   function automatic logic [1:0] rr_slot(input logic [1:0] last,
                                          input logic [1:0] step);
      logic [1:0] base;
      logic [2:0] sum;
      base = (last == 2'd3) ? 2'd2 : last;
      sum  = {1'b0, base} + {1'b0, step} + 3'd1;
      // sum is in 1..5; fold into 0..2
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return sum[1:0];
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// rr_pick3
//   Purely combinational round-robin winner selection among 3 requesters.
//   Ports:
//     i_req[2:0]     raw requests
//     i_last[1:0]    previous winner; priority starts just after it
//     i_exclude[2:0] requesters removed from this arbitration
//     o_valid        at least one non-excluded request is present
//     o_winner[1:0]  highest-priority non-excluded requester (0 when !o_valid)
module rr_pick3
   import mux3_rr_arbiter_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_last,
   input  logic [2:0] i_exclude,
   output logic       o_valid,
   output logic [1:0] o_winner
);

   logic [2:0] w_masked;
   logic [1:0] w_order [3];

   assign w_masked = i_req & ~i_exclude;
   assign o_valid  = |w_masked;

   for (genvar gi = 0; gi < 3; gi++) begin : g_order
      assign w_order[gi] = rr_slot(i_last, 2'(gi));
   end

   // Walk the order from lowest to highest priority so the earliest
   // active slot is the one left standing.
   always_comb begin
      o_winner = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (|(w_masked & onehot3(w_order[k]))) begin
            o_winner = w_order[k];
         end
      end
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter
//   Round-robin arbiter owning the select of a shared 3:1 mux. An owner keeps
//   the path while its request stays high, up to MAX_HOLD consecutive cycles
//   (0 = unlimited); on timeout another requester is preferred, and the owner
//   is simply re-granted if nobody else wants the path.
//   Ports:
//     i_clk          clock, all state updates on rising edge
//     i_rst          asynchronous active-high reset
//     i_req[2:0]     per-requester request, held while the path is needed
//     o_control[1:0] registered mux select (0..2); holds its value when idle
//     o_grant[2:0]   registered one-hot owner, zero when there is no owner
//     o_busy         high exactly when o_grant is non-zero
//     o_expired      one-cycle pulse after an ownership ended by timeout
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_req,
   output logic [1:0] o_control,
   output logic [2:0] o_grant,
   output logic       o_busy,
   output logic       o_expired
);

   localparam int unsigned          HOLD_W     = hold_width(MAX_HOLD);
   localparam logic [HOLD_W-1:0]    HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0]    HOLD_ONE   = HOLD_W'(1);
   localparam logic                 TIMEOUT_EN = (MAX_HOLD != 0);

   arb_state_t        r_state, w_state_next;
   logic [1:0]        r_owner, w_owner_next;
   logic [1:0]        r_last,  w_last_next;
   logic [HOLD_W-1:0] r_hold,  w_hold_next;
   logic [1:0]        r_control, w_control_next;
   logic [2:0]        r_grant,   w_grant_next;
   logic              r_expired, w_expired_next;

   logic              w_owner_req;
   logic              w_timeout;
   logic [2:0]        w_exclude;
   logic              w_pick_valid;
   logic [1:0]        w_pick_winner;

   assign w_owner_req = |(i_req & onehot3(r_owner));
   assign w_timeout   = TIMEOUT_EN && (r_state == ST_OWN) &&
                        (r_hold == HOLD_LIMIT) && w_owner_req;
   // The timed-out owner sits out this arbitration only.
   assign w_exclude   = w_timeout ? onehot3(r_owner) : 3'b000;

   rr_pick3 u_pick (
      .i_req     (i_req),
      .i_last    (r_last),
      .i_exclude (w_exclude),
      .o_valid   (w_pick_valid),
      .o_winner  (w_pick_winner)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_owner   <= 2'd0;
         r_last    <= 2'd2;
         r_hold    <= '0;
         r_control <= 2'd0;
         r_grant   <= 3'b000;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_owner   <= w_owner_next;
         r_last    <= w_last_next;
         r_hold    <= w_hold_next;
         r_control <= w_control_next;
         r_grant   <= w_grant_next;
         r_expired <= w_expired_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_owner_next   = r_owner;
      w_last_next    = r_last;
      w_hold_next    = r_hold;
      w_control_next = r_control;
      w_grant_next   = r_grant;
      w_expired_next = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state_next   = ST_OWN;
               w_owner_next   = w_pick_winner;
               w_last_next    = w_pick_winner;
               w_hold_next    = HOLD_ONE;
               w_control_next = w_pick_winner;
               w_grant_next   = onehot3(w_pick_winner);
            end
         end

         ST_OWN: begin
            if (w_timeout) begin
               w_expired_next = 1'b1;
               w_hold_next    = HOLD_ONE;
               // With nobody else requesting, the owner keeps the path and
               // the defaults already hold owner/grant/control.
               if (w_pick_valid) begin
                  w_owner_next   = w_pick_winner;
                  w_last_next    = w_pick_winner;
                  w_control_next = w_pick_winner;
                  w_grant_next   = onehot3(w_pick_winner);
               end
            end else if (w_owner_req) begin
               if (TIMEOUT_EN && (r_hold != HOLD_LIMIT)) begin
                  w_hold_next = r_hold + HOLD_ONE;
               end
            end else if (w_pick_valid) begin
               // Hand over in the same edge: no dead cycle between owners.
               w_owner_next   = w_pick_winner;
               w_last_next    = w_pick_winner;
               w_hold_next    = HOLD_ONE;
               w_control_next = w_pick_winner;
               w_grant_next   = onehot3(w_pick_winner);
            end else begin
               w_state_next = ST_IDLE;
               w_grant_next = 3'b000;
               w_hold_next  = '0;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
            w_grant_next = 3'b000;
         end
      endcase
   end

   assign o_control = r_control;
   assign o_grant   = r_grant;
   assign o_busy    = |r_grant;
   assign o_expired = r_expired;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter
//   Directed table of single-cycle vectors plus hand-written multi-cycle
//   sequences (timeout hand-over, continuous re-grant, async reset) and a
//   sticky random request run with invariant and wait-time checks.
module tb_mux3_rr_arbiter;

   logic       clk;
   logic       rst_a, rst_b;
   logic [2:0] req_a, req_b;
   logic [1:0] control_a, control_b;
   logic [2:0] grant_a, grant_b;
   logic       busy_a, busy_b;
   logic       expired_a, expired_b;

   int checks   = 0;
   int failures = 0;

   mux3_rr_arbiter #(.MAX_HOLD(15)) dut_a (
      .i_clk     (clk),
      .i_rst     (rst_a),
      .i_req     (req_a),
      .o_control (control_a),
      .o_grant   (grant_a),
      .o_busy    (busy_a),
      .o_expired (expired_a)
   );

   mux3_rr_arbiter #(.MAX_HOLD(4)) dut_b (
      .i_clk     (clk),
      .i_rst     (rst_b),
      .i_req     (req_b),
      .o_control (control_b),
      .o_grant   (grant_b),
      .o_busy    (busy_b),
      .o_expired (expired_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] req;
      logic [2:0] grant;
      logic [1:0] control;
      logic       busy;
      logic       expired;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wait_cnt [3];
      int max_wait;
      int bad_ctrl, bad_onehot, bad_busy;

      // {req applied before edge, expected grant/control/busy/expired after it}
      vecs[0]  = '{3'b111, 3'b001, 2'd0, 1'b1, 1'b0};
      vecs[1]  = '{3'b110, 3'b010, 2'd1, 1'b1, 1'b0};
      vecs[2]  = '{3'b100, 3'b100, 2'd2, 1'b1, 1'b0};
      vecs[3]  = '{3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
      vecs[4]  = '{3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
      vecs[5]  = '{3'b011, 3'b001, 2'd0, 1'b1, 1'b0};
      vecs[6]  = '{3'b011, 3'b001, 2'd0, 1'b1, 1'b0};
      vecs[7]  = '{3'b010, 3'b010, 2'd1, 1'b1, 1'b0};
      vecs[8]  = '{3'b111, 3'b010, 2'd1, 1'b1, 1'b0};
      vecs[9]  = '{3'b101, 3'b100, 2'd2, 1'b1, 1'b0};
      vecs[10] = '{3'b001, 3'b001, 2'd0, 1'b1, 1'b0};
      vecs[11] = '{3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
      vecs[12] = '{3'b110, 3'b010, 2'd1, 1'b1, 1'b0};
      vecs[13] = '{3'b000, 3'b000, 2'd1, 1'b0, 1'b0};

      rst_a = 1'b1;
      rst_b = 1'b1;
      req_a = 3'b000;
      req_b = 3'b000;
      tick();
      tick();
      check("rst_grant",   int'(grant_a),   0);
      check("rst_control", int'(control_a), 0);
      check("rst_busy",    int'(busy_a),    0);
      check("rst_expired", int'(expired_a), 0);
      check("rst_b_grant", int'(grant_b),   0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Directed table
      for (int v = 0; v < 14; v++) begin
         req_a = vecs[v].req;
         tick();
         $display("vec %0d req=%b grant=%b control=%0d busy=%0d expired=%0d",
                  v, req_a, grant_a, control_a, busy_a, expired_a);
         check($sformatf("vec%0d_grant", v),   int'(grant_a),   int'(vecs[v].grant));
         check($sformatf("vec%0d_control", v), int'(control_a), int'(vecs[v].control));
         check($sformatf("vec%0d_busy", v),    int'(busy_a),    int'(vecs[v].busy));
         check($sformatf("vec%0d_expired", v), int'(expired_a), int'(vecs[v].expired));
      end

      // Timeout hand-over: owner 1 for 15 cycles, req[0] raised at cycle 5
      req_a = 3'b010;
      for (int c = 1; c <= 15; c++) begin
         tick();
         $display("hold c=%0d grant=%b expired=%0d", c, grant_a, expired_a);
         check($sformatf("hold%0d_grant", c),   int'(grant_a),   2);
         check($sformatf("hold%0d_expired", c), int'(expired_a), 0);
         if (c == 5) req_a = 3'b011;
      end
      tick();
      $display("timeout grant=%b control=%0d expired=%0d", grant_a, control_a, expired_a);
      check("timeout_grant",   int'(grant_a),   1);
      check("timeout_control", int'(control_a), 0);
      check("timeout_expired", int'(expired_a), 1);
      tick();
      $display("post_timeout grant=%b expired=%0d", grant_a, expired_a);
      check("post_timeout_expired", int'(expired_a), 0);
      check("post_timeout_grant",   int'(grant_a),   1);
      req_a = 3'b000;
      tick();
      check("drop_to_idle", int'(grant_a), 0);

      // MAX_HOLD = 4, lone requester 2: continuous grant, expired every 4 cycles
      req_b = 3'b100;
      for (int k = 1; k <= 20; k++) begin
         tick();
         $display("lone k=%0d grant=%b control=%0d expired=%0d", k, grant_b, control_b, expired_b);
         check($sformatf("lone%0d_grant", k),   int'(grant_b),   4);
         check($sformatf("lone%0d_control", k), int'(control_b), 2);
         check($sformatf("lone%0d_expired", k), int'(expired_b),
               ((k >= 5) && (k % 4 == 1)) ? 1 : 0);
      end
      req_b = 3'b000;

      // Async reset mid-ownership (last = 0 here, so requester 1 wins)
      req_a = 3'b010;
      tick();
      check("pre_rst_grant", int'(grant_a), 2);
      tick();
      #3 rst_a = 1'b1;
      #1;
      $display("async_rst grant=%b control=%0d busy=%0d", grant_a, control_a, busy_a);
      check("async_rst_grant",   int'(grant_a),   0);
      check("async_rst_control", int'(control_a), 0);
      check("async_rst_busy",    int'(busy_a),    0);
      check("async_rst_expired", int'(expired_a), 0);
      req_a = 3'b110;
      #2 rst_a = 1'b0;
      tick();
      $display("post_rst grant=%b control=%0d", grant_a, control_a);
      check("post_rst_grant",   int'(grant_a),   2);
      check("post_rst_control", int'(control_a), 1);
      check("post_rst_expired", int'(expired_a), 0);

      // Sticky random requests: a waiting requester never withdraws
      req_a = 3'b000;
      tick();
      max_wait   = 0;
      bad_ctrl   = 0;
      bad_onehot = 0;
      bad_busy   = 0;
      for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (req_a[i]) begin
               if (grant_a[i]) req_a[i] = ($urandom_range(3) != 0);
            end else begin
               req_a[i] = ($urandom_range(2) == 0);
            end
         end
         tick();
         if (control_a == 2'd3) bad_ctrl++;
         if (!$onehot0(grant_a)) bad_onehot++;
         if (busy_a != (|grant_a)) bad_busy++;
         for (int i = 0; i < 3; i++) begin
            if (req_a[i] && !grant_a[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
      end
      $display("random ctrl3=%0d not_onehot=%0d busy_bad=%0d max_wait=%0d",
               bad_ctrl, bad_onehot, bad_busy, max_wait);
      check("rand_control_3",   bad_ctrl,   0);
      check("rand_grant_onehot", bad_onehot, 0);
      check("rand_busy",         bad_busy,   0);
      check("rand_wait_bound",   (max_wait <= 2 * 15 + 2) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux3_rr_arbiter.md
MUX3_RR_ARBITER -- requirements
Module: mux3_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 15, is the maximum number of consecutive grant cycles per ownership; 0 disables the timeout.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  request per requester; req[i] is held high for as long as requester i needs the shared 3-input mux path.
REQ-005 control  output  2  select driven to the shared 3:1 mux, registered; legal values 0, 1 and 2 only; value 3 never driven.
REQ-006 grant  output  3  one-hot owner indication, registered; all-zero when there is no owner.
REQ-007 busy  output  1  high exactly when grant is non-zero.
REQ-008 expired  output  1  single-cycle pulse, high in the cycle after an ownership ends by timeout.

Function
REQ-009 The arbiter has two states: IDLE (no owner) and OWN (one owner, held in a 2-bit owner register).
REQ-010 The last-winner register (last) sets round-robin priority: order is (last+1) mod 3, (last+2) mod 3, then last.
REQ-011 In IDLE, at a rising edge where req is non-zero, the highest-priority requester wins: state becomes OWN, owner becomes the winner, last becomes the winner, and the hold counter becomes 1.
REQ-012 Grant latency is one cycle: a request sampled at edge N appears on grant and control after edge N.
REQ-013 In OWN, control equals owner and grant equals the one-hot encoding of owner.
REQ-014 In IDLE, control holds its previous value and grant is 0.
REQ-015 In OWN, when req[owner] is sampled high and no timeout occurs, ownership is retained and the hold counter increments, saturating at MAX_HOLD.
REQ-016 In OWN, when req[owner] is sampled low, the edge re-arbitrates among req as in REQ-011; if req is 0, state becomes IDLE. There are no dead cycles between owners.
REQ-017 Timeout condition: MAX_HOLD != 0, the hold counter equals MAX_HOLD, and req[owner] is high.
REQ-018 On timeout, the edge re-arbitrates with the current owner excluded. If no other requester is active, the same owner is re-granted with the counter reset to 1. In both cases expired pulses for one cycle.
REQ-019 Simultaneous requests in IDLE are resolved by REQ-010 only; there is no fixed index priority.
REQ-020 A req change on a requester that is not the owner never affects the current grant.
REQ-021 The hold counter width is the smallest width that holds MAX_HOLD, minimum 1 bit.

Reset
REQ-022 While reset is high: state = IDLE, control = 0, grant = 0, busy = 0, expired = 0, hold counter = 0, last = 2 (so requester 0 has first priority).
REQ-023 Reset asserted mid-ownership drops grant immediately and asynchronously, with no expired pulse.
REQ-024 The first arbitration occurs at the first rising edge after reset deasserts.

Structure
REQ-025 A shared package holds the state encoding (IDLE = 0, OWN = 1), NUM_REQ = 3 and the default MAX_HOLD.
REQ-026 The round-robin winner selection is a combinational sub-module, rr_pick3, with inputs req[2:0], last[1:0] and an exclude mask[2:0], and outputs valid and winner[1:0].
REQ-027 No combinational path from req to control, grant or busy.

Verification
REQ-028 Reset, then req = 3'b111 held -> after edge 1: grant = 001, control = 0, busy = 1; drop req[0] -> next cycle grant = 010, control = 1; drop req[1] -> grant = 100, control = 2.
REQ-029 req = 3'b010 held for 20 cycles with MAX_HOLD = 15, req[0] raised at cycle 5 -> owner 1 for 15 cycles, then expired = 1 for one cycle, grant = 001.
REQ-030 Only req[2] held, MAX_HOLD = 4 -> grant = 100 is continuous, and expired pulses every 4 cycles with control staying at 2.
REQ-031 Owner 1 holding; reset pulsed asynchronously mid-cycle -> grant = 0 and control = 0 before the next edge; after release with req = 3'b110 -> grant = 010 (priority starts at requester 0, which is not requesting).
REQ-032 Random req for 10k cycles -> control is never 3, grant is always one-hot or zero, busy == |grant, and no requester holding req waits more than 2*MAX_HOLD + 2 cycles.
